alu_seq_exec: RTL and testbench
===============================

// Module: alu_seq_exec
// PURPOSE
//   Execution-side consumer of the 3-bit ALU control code emitted by the ALU control decoder.
//   Accepts one operation per valid/ready handshake: 2 operands plus code.
//   Returns a registered result through a valid/ready output port.
//   SLL runs iteratively, 1 bit per cycle; every other op completes in 1 cycle.
//   Sits between the register-read stage and writeback of the multi-cycle datapath.
// PARAMETERS
//   XLEN     32   operand/result width; power of 2, >= 8
//   SHAMT_W  5    shift-amount width; localparam = $clog2(XLEN), not overridable
// PORTS
//   clk        in   1        single clock, rising edge
//   rst        in   1        asynchronous, active-high reset
//   in_valid   in   1        operation request
//   in_ready   out  1        block can accept; high only in IDLE
//   alu_ctrl   in   3        000 SUB, 001 ADD, 010 AND, 011 OR, 100 SLL, 110 SLT; 101/111 illegal
//   op_a       in   XLEN     operand A, rs1
//   op_b       in   XLEN     operand B, rs2; SLL uses op_b[SHAMT_W-1:0] only
//   out_valid  out  1        result available
//   out_ready  in   1        downstream accepts result
//   result     out  XLEN     registered result
//   illegal    out  1        result belongs to an illegal alu_ctrl code
//   busy       out  1        high in SHIFT or DONE
// BEHAVIOUR
//   Reset (async): state=IDLE; result=0, out_valid=0, illegal=0, busy=0; flags=0 if present.
//   in_ready=1 out of reset.
//   States:
//   - IDLE: in_ready=1. Accept on in_valid && in_ready; operands and code are sampled only here.
//   - SHIFT: in_ready=0. acc <= acc<<1, cnt <= cnt-1 each cycle. When cnt==1, the final shift
//     occurs and state goes to DONE.
//   - DONE: out_valid=1. result/illegal/flags are held stable until out_valid && out_ready,
//     then state goes to IDLE.
//   IDLE transitions on accept:
//   - non-SLL or illegal code -> DONE with result latched.
//   - SLL with shamt=0 -> DONE with result = op_a.
//   - SLL with shamt>0 -> SHIFT with acc = op_a, cnt = shamt.
//   Latency, accept edge to out_valid: 1 cycle, or 1 + shamt for SLL.
//   Min issue interval: 2 cycles; in_ready=0 during DONE, no same-cycle re-accept.
//   Arithmetic: ADD/SUB are mod 2^XLEN. AND/OR are bitwise. SLT is a signed compare,
//   result = {XLEN-1 zeros, lt}. SLL zero-fills.
//   Illegal code: result=0, illegal=1, latency 1. The normal handshake still applies.
//   in_valid while not in IDLE: ignored, nothing captured, no state change.
//   out_ready while out_valid=0: ignored.
//   Input changes after accept do not affect the in-flight op.
//   rst asserted mid-SHIFT or in DONE: op is aborted and discarded; all outputs return to
//   reset values immediately.
// CONFIGURATION
//   ALU_FLAGS_EN defined: adds outputs zero (1 bit) and ovf (1 bit). Both are registered with
//   result and held with it.
//   - zero = (result == 0).
//   - ovf = signed overflow for ADD/SUB; 0 for all other codes and for illegal codes.
//   ALU_FLAGS_EN undefined: the zero and ovf ports and their logic are absent. All other
//   behaviour is identical.
// TESTING
//   1. ADD: op_a=5, op_b=7, out_ready=1 -> out_valid 1 cycle after accept, result=12,
//      illegal=0, in_ready back to 1 the next cycle.
//   2. SUB/SLT: 3-5 -> 0xFFFFFFFE. SLT -1,1 -> 1; SLT 1,-1 -> 0. With ALU_FLAGS_EN:
//      0x80000000-1 -> 0x7FFFFFFF, ovf=1; 5-5 -> zero=1.
//   3. SLL:
//      - op_a=1, op_b=31 -> result 0x80000000, out_valid exactly 32 cycles after accept.
//      - op_b=0x25 -> shamt 5, result 0x20, latency 6.
//      - op_b=0 -> result=op_a, latency 1.
//   4. Illegal: alu_ctrl=101 and 111 -> result=0, illegal=1, latency 1. The next legal op
//      clears illegal.
//   5. Backpressure: out_ready=0 for 4 cycles after out_valid -> result/out_valid stable,
//      in_ready=0, a concurrent in_valid is not captured. Then out_ready=1 -> IDLE next cycle.
//   6. Reset: rst pulse on cycle 3 of a 10-bit SLL -> out_valid=0, busy=0, result=0
//      immediately. After release, in_ready=1 and an ADD 1+1 returns 2.

Source files
------------

// File: rtl/alu_seq_exec.sv
// Execution unit for the 3-bit ALU control code: single-cycle ADD/SUB/AND/OR/SLT,
// iterative 1-bit-per-cycle SLL. Optional zero/ovf flag outputs under `ALU_FLAGS_EN.
module alu_seq_exec #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      alu_ctrl,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            illegal,
  output logic            busy
`ifdef ALU_FLAGS_EN
  ,
  output logic            zero,
  output logic            ovf
`endif
);

  localparam int unsigned SHAMT_W = $clog2(XLEN);

  localparam logic [2:0] OP_SUB = 3'b000;
  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_SLL = 3'b100;
  localparam logic [2:0] OP_SLT = 3'b110;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]         state_q, state_n;
  logic [XLEN-1:0]    acc_q, acc_n;
  logic [SHAMT_W-1:0] cnt_q, cnt_n;
  logic [XLEN-1:0]    result_n;
  logic               illegal_n;

  logic [SHAMT_W-1:0] shamt_c;
  logic [XLEN-1:0]    sum_c, diff_c, alu_res_c;
  logic               lt_c, legal_c;

  assign shamt_c = op_b[SHAMT_W-1:0];
  assign sum_c   = op_a + op_b;
  assign diff_c  = op_a - op_b;
  assign lt_c    = $signed(op_a) < $signed(op_b);

  // Single-cycle result; SLL here only covers the zero-shift case
  always_comb begin
    alu_res_c = '0;
    legal_c   = 1'b1;
    case (alu_ctrl)
      OP_SUB:  alu_res_c = diff_c;
      OP_ADD:  alu_res_c = sum_c;
      OP_AND:  alu_res_c = op_a & op_b;
      OP_OR:   alu_res_c = op_a | op_b;
      OP_SLL:  alu_res_c = op_a;
      OP_SLT:  alu_res_c = {{(XLEN-1){1'b0}}, lt_c};
      default: legal_c   = 1'b0;
    endcase
  end

  // Next-state and datapath update
  always_comb begin
    state_n   = state_q;
    acc_n     = acc_q;
    cnt_n     = cnt_q;
    result_n  = result;
    illegal_n = illegal;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          if (alu_ctrl == OP_SLL && shamt_c != '0) begin
            state_n = S_SHIFT;
            acc_n   = op_a;
            cnt_n   = shamt_c;
          end else begin
            state_n   = S_DONE;
            result_n  = alu_res_c;
            illegal_n = ~legal_c;
          end
        end
      end
      S_SHIFT: begin
        acc_n = acc_q << 1;
        cnt_n = cnt_q - SHAMT_W'(1);
        if (cnt_q == SHAMT_W'(1)) begin
          state_n   = S_DONE;
          result_n  = acc_q << 1;
          illegal_n = 1'b0;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_n = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // State, datapath and registered handshake outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      acc_q     <= '0;
      cnt_q     <= '0;
      result    <= '0;
      illegal   <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_n;
      acc_q     <= acc_n;
      cnt_q     <= cnt_n;
      result    <= result_n;
      illegal   <= illegal_n;
      in_ready  <= (state_n == S_IDLE);
      out_valid <= (state_n == S_DONE);
      busy      <= (state_n != S_IDLE);
    end
  end

`ifdef ALU_FLAGS_EN
  logic ovf_c;

  // Signed overflow: operands agree in sign (ADD) or differ (SUB) and the result sign flips
  always_comb begin
    ovf_c = 1'b0;
    case (alu_ctrl)
      OP_ADD:  ovf_c = (op_a[XLEN-1] == op_b[XLEN-1]) && (sum_c[XLEN-1] != op_a[XLEN-1]);
      OP_SUB:  ovf_c = (op_a[XLEN-1] != op_b[XLEN-1]) && (diff_c[XLEN-1] != op_a[XLEN-1]);
      default: ovf_c = 1'b0;
    endcase
  end

  // Flags load together with result on entry to DONE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      zero <= 1'b0;
      ovf  <= 1'b0;
    end else if (state_q != S_DONE && state_n == S_DONE) begin
      zero <= (result_n == '0);
      ovf  <= (state_q == S_IDLE) && ovf_c;
    end
  end
`endif

endmodule

// File: tb/tb_alu_seq_exec.sv
// Self-checking bench for alu_seq_exec: directed cases plus randomized ops against a behavioural model.
module tb_alu_seq_exec;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  alu_ctrl;
  logic [31:0] op_a, op_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        illegal;
  logic        busy;
`ifdef ALU_FLAGS_EN
  logic        zero, ovf;
`endif

  int checks   = 0;
  int failures = 0;

  logic        exp_pending = 1'b0;
  logic [31:0] exp_res;
  logic        exp_ill;
  logic        exp_zero, exp_ovf;

  alu_seq_exec #(.XLEN(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .alu_ctrl  (alu_ctrl),
    .op_a      (op_a),
    .op_b      (op_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .illegal   (illegal),
    .busy      (busy)
`ifdef ALU_FLAGS_EN
    ,
    .zero      (zero),
    .ovf       (ovf)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Behavioural model: {illegal, result}
  function automatic logic [32:0] model(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
    case (c)
      3'd0:    return {1'b0, a - b};
      3'd1:    return {1'b0, a + b};
      3'd2:    return {1'b0, a & b};
      3'd3:    return {1'b0, a | b};
      3'd4:    return {1'b0, a << b[4:0]};
      3'd6:    return {1'b0, 31'd0, ($signed(a) < $signed(b))};
      default: return {1'b1, 32'd0};
    endcase
  endfunction

  function automatic logic model_ovf(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
    longint s;
    if (c == 3'd0)      s = longint'($signed(a)) - longint'($signed(b));
    else if (c == 3'd1) s = longint'($signed(a)) + longint'($signed(b));
    else return 1'b0;
    return (s > 64'sd2147483647) || (s < -64'sd2147483648);
  endfunction

  // Every cycle with an op in flight: result fields while valid, stall signals otherwise
  always @(negedge clk) begin
    if (!rst && exp_pending) begin
      if (out_valid) begin
        check("result", 64'(result), 64'(exp_res));
        check("illegal", 64'(illegal), 64'(exp_ill));
        check("in_ready_done", 64'(in_ready), 64'd0);
        check("busy_done", 64'(busy), 64'd1);
`ifdef ALU_FLAGS_EN
        check("zero", 64'(zero), 64'(exp_zero));
        check("ovf", 64'(ovf), 64'(exp_ovf));
`endif
      end else begin
        check("in_ready_shift", 64'(in_ready), 64'd0);
        check("busy_shift", 64'(busy), 64'd1);
      end
    end
  end

  task automatic run_op(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b, input int bp,
                        input bit lit, input logic [31:0] lres, input logic lill, input int llat);
    logic [32:0] m;
    int lat, exp_lat, guard;
    guard = 0;
    while (!in_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) begin
      check("in_ready_wait", 64'(in_ready), 64'd1);
      return;
    end
    alu_ctrl  = c;
    op_a      = a;
    op_b      = b;
    in_valid  = 1'b1;
    out_ready = 1'($urandom_range(0, 1));
    m       = model(c, a, b);
    exp_lat = (c == 3'd4) ? 1 + int'(b[4:0]) : 1;
    if (lit) begin
      exp_res = lres;
      exp_ill = lill;
      exp_lat = llat;
    end else begin
      exp_res = m[31:0];
      exp_ill = m[32];
    end
    exp_zero = (exp_res == 32'd0);
    exp_ovf  = model_ovf(c, a, b);
    @(posedge clk);
    exp_pending = 1'b1;
    #1;
    // Inputs wander after accept; none of it may reach the in-flight op
    in_valid = 1'($urandom_range(0, 1));
    alu_ctrl = 3'($urandom);
    op_a     = $urandom;
    op_b     = $urandom;
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("latency", 64'(lat), 64'(exp_lat));
    if (!out_valid) begin
      exp_pending = 1'b0;
      in_valid    = 1'b0;
      return;
    end
    out_ready = 1'b0;
    in_valid  = 1'b1;
    repeat (bp) begin
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    out_ready = 1'b1;
    in_valid  = 1'b0;
    @(posedge clk);
    #1;
    exp_pending = 1'b0;
    check("in_ready_after", 64'(in_ready), 64'd1);
    check("out_valid_after", 64'(out_valid), 64'd0);
    check("busy_after", 64'(busy), 64'd0);
    out_ready = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    alu_ctrl  = 3'd0;
    op_a      = 32'd0;
    op_b      = 32'd0;
    #12;
    check("rst_result", 64'(result), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_illegal", 64'(illegal), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    run_op(3'd1, 32'd5, 32'd7, 0, 1, 32'd12, 1'b0, 1);
    run_op(3'd0, 32'd3, 32'd5, 0, 1, 32'hFFFF_FFFE, 1'b0, 1);
    run_op(3'd6, 32'hFFFF_FFFF, 32'd1, 1, 1, 32'd1, 1'b0, 1);
    run_op(3'd6, 32'd1, 32'hFFFF_FFFF, 0, 1, 32'd0, 1'b0, 1);
    run_op(3'd0, 32'h8000_0000, 32'd1, 0, 1, 32'h7FFF_FFFF, 1'b0, 1);
    run_op(3'd0, 32'd5, 32'd5, 0, 1, 32'd0, 1'b0, 1);
    run_op(3'd2, 32'hFF00_FF00, 32'h0FF0_0FF0, 0, 1, 32'h0F00_0F00, 1'b0, 1);
    run_op(3'd4, 32'd1, 32'd31, 0, 1, 32'h8000_0000, 1'b0, 32);
    run_op(3'd4, 32'd1, 32'h25, 0, 1, 32'h20, 1'b0, 6);
    run_op(3'd4, 32'hDEAD_BEEF, 32'd0, 0, 1, 32'hDEAD_BEEF, 1'b0, 1);
    run_op(3'd5, 32'h1234, 32'h5678, 0, 1, 32'd0, 1'b1, 1);
    run_op(3'd7, 32'hFFFF_FFFF, 32'd9, 0, 1, 32'd0, 1'b1, 1);
    run_op(3'd3, 32'hF0, 32'h0F, 0, 1, 32'hFF, 1'b0, 1);
    run_op(3'd1, 32'h100, 32'h23, 4, 1, 32'h123, 1'b0, 1);

    // Reset in the middle of a 10-bit shift
    alu_ctrl = 3'd4;
    op_a     = 32'd3;
    op_b     = 32'd10;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_result", 64'(result), 64'd0);
    check("midrst_illegal", 64'(illegal), 64'd0);
    check("midrst_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", 64'(in_ready), 64'd1);
    run_op(3'd1, 32'd1, 32'd1, 0, 1, 32'd2, 1'b0, 1);

    for (int i = 0; i < 40; i++) begin
      logic [2:0]  c;
      logic [31:0] a, b;
      c = 3'($urandom_range(0, 7));
      a = $urandom;
      b = $urandom;
      if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(0, 3));
      if ($urandom_range(0, 5) == 0) a = b;
      run_op(c, a, b, $urandom_range(0, 3), 0, 32'd0, 1'b0, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
